// File: rtl/alu_mul_seq_if.sv
// Execute-side and ALU-side signal bundle for the shift-and-add multiply sequencer.
// master: execute stage plus shared ALU; slave: the sequencer itself.
interface alu_mul_seq_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OP_WIDTH   = 26
);
    logic                  start;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] alu_srca;
    logic [DATA_WIDTH-1:0] alu_srcb;
    logic [OP_WIDTH-1:0]   alu_op;
    logic [DATA_WIDTH-1:0] alu_result;

    modport master (
        output start, op_a, op_b, alu_result,
        input  busy, done, result, alu_srca, alu_srcb, alu_op
    );

    modport slave (
        input  start, op_a, op_b, alu_result,
        output busy, done, result, alu_srca, alu_srcb, alu_op
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned shift-and-add multiplier that borrows the shared ALU adder.
// Produces the low DATA_WIDTH bits of op_a*op_b (also the correct low word for signed MUL).
// Optional macro ALU_MUL_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier bits are zero.
module alu_mul_seq #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          OP_WIDTH   = 26,
    parameter logic [OP_WIDTH-1:0]  OP_ADD     = OP_WIDTH'(26'b10)
) (
    input  logic          clk,
    input  logic          reset,
    alu_mul_seq_if.slave  bus
);
    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0] r_mplier;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_acc_next;
    logic [DATA_WIDTH-1:0] w_alu_srca;
    logic [DATA_WIDTH-1:0] w_alu_srcb;
    logic [OP_WIDTH-1:0]   w_alu_op;

    // Accumulator takes the ALU sum only when the current multiplier bit is set
    assign w_acc_next = r_mplier[0] ? bus.alu_result : r_acc;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and ALU drive, decoded from registered state only
    always_comb begin
        w_state_next = r_state;
        w_alu_srca   = '0;
        w_alu_srcb   = '0;
        w_alu_op     = '0;
        w_last       = (r_count == CNT_W'(DATA_WIDTH - 1));
`ifdef ALU_MUL_EARLY_TERM_EN
        w_last       = w_last | (r_mplier[DATA_WIDTH-1:1] == '0);
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_alu_srca = r_acc;
                w_alu_srcb = r_mcand;
                w_alu_op   = r_mplier[0] ? OP_ADD : '0;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, one shift-add iteration per RUN cycle, result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_acc    <= '0;
                        r_mcand  <= bus.op_a;
                        r_mplier <= bus.op_b;
                        r_count  <= '0;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CNT_W'(1);
                    if (w_last) begin
                        r_result <= w_acc_next;
                    end
                end
                default: begin
                end
            endcase
            r_busy <= (w_state_next == S_RUN);
            r_done <= (w_state_next == S_DONE);
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.alu_srca = w_alu_srca;
    assign bus.alu_srcb = w_alu_srcb;
    assign bus.alu_op   = w_alu_op;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: ALU modelled as ADD-or-zero, products checked against a*b mod 2^32.
module tb_alu_mul_seq;
    localparam int unsigned DW = 32;
    localparam int unsigned OW = 26;
    localparam logic [OW-1:0] ADD_CODE = 26'b10;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_mul_seq_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) bus ();

    // Shared ALU: only ADD is exercised, everything else returns 0
    assign bus.alu_result = (bus.alu_op == ADD_CODE) ? (bus.alu_srca + bus.alu_srcb) : '0;

    alu_mul_seq #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .OP_ADD(ADD_CODE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [DW-1:0] ref_prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [2*DW-1:0] p;
        p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        return p[DW-1:0];
    endfunction

    // Cycles from the accepting cycle to the done cycle, inclusive
    function automatic int ref_lat(input logic [DW-1:0] b);
`ifdef ALU_MUL_EARLY_TERM_EN
        int n;
        n = 1;
        for (int i = 0; i < int'(DW); i++) begin
            if (b[i]) n = i + 1;
        end
        return n + 1;
`else
        if (b == 0) return DW + 1;
        return DW + 1;
`endif
    endfunction

    // Issue one multiply from IDLE, wait for done (bounded), then step back to IDLE
    task automatic do_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          output logic [DW-1:0] res, output int lat, output int busy_cyc,
                          output bit op_bad, output bit timeout, output bit extra_done);
        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1; busy_cyc = 0; op_bad = 1'b0;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (bus.busy === 1'b1) busy_cyc++;
            if (!(bus.alu_op === '0 || (bus.alu_op === ADD_CODE && bus.busy === 1'b1))) op_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        timeout = (bus.done !== 1'b1);
        res = bus.result;
        if (bus.busy !== 1'b0 || bus.alu_op !== '0) op_bad = 1'b1;
        @(posedge clk); #1;
        extra_done = (bus.done !== 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", bus.done); end
        total++; if (bus.result !== '0) begin bad++; $display("FAIL reset_result: got %0h want 0", bus.result); end
        total++; if (bus.alu_op !== '0 || bus.alu_srca !== '0 || bus.alu_srcb !== '0) begin
            bad++; $display("FAIL reset_alu: op %0h srca %0h srcb %0h want all 0", bus.alu_op, bus.alu_srca, bus.alu_srcb);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [DW-1:0] res; int lat, bc; bit ob, to, xd;
        do_mul(32'd7, 32'd6, res, lat, bc, ob, to, xd);
        total++; if (to) begin bad++; $display("FAIL basic_timeout: got no done want done"); end
        total++; if (res !== 32'd42) begin bad++; $display("FAIL basic_result: got %0d want 42", res); end
        total++; if (lat != ref_lat(32'd6)) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, ref_lat(32'd6)); end
        total++; if (bc != ref_lat(32'd6) - 1) begin bad++; $display("FAIL basic_busy_cycles: got %0d want %0d", bc, ref_lat(32'd6) - 1); end
        total++; if (ob) begin bad++; $display("FAIL basic_alu_op: got stray op want 0/ADD in RUN only"); end
        total++; if (xd) begin bad++; $display("FAIL basic_single_done: got done twice want one pulse"); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.result !== 32'd42) begin bad++; $display("FAIL basic_result_hold: got %0d want 42", bus.result); end
    endtask

    task automatic test_corners();
        logic [DW-1:0] ta [6] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd12345, 32'd0, 32'hCAFE_F00D, 32'd123};
        logic [DW-1:0] tb [6] = '{32'hFFFF_FFFF, 32'd2,         32'd0,     32'd99, 32'd1,       32'd5};
        logic [DW-1:0] res; int lat, bc; bit ob, to, xd;
        for (int i = 0; i < 6; i++) begin
            do_mul(ta[i], tb[i], res, lat, bc, ob, to, xd);
            total++; if (res !== ref_prod(ta[i], tb[i]) || to) begin
                bad++; $display("FAIL corner_result[%0d]: got %0h want %0h", i, res, ref_prod(ta[i], tb[i]));
            end
            total++; if (lat != ref_lat(tb[i]) || ob || xd) begin
                bad++; $display("FAIL corner_timing[%0d]: got lat %0d op_bad %0b extra %0b want lat %0d", i, lat, ob, xd, ref_lat(tb[i]));
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [DW-1:0] a, b; int lat;
        a = 32'h0000_1234; b = 32'h8000_0055;
        bus.op_a = a; bus.op_b = b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 200) begin
            bus.start = (lat == 10);
            if (lat >= 10) begin
                bus.op_a = $urandom; bus.op_b = $urandom;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        total++; if (bus.result !== ref_prod(a, b)) begin bad++; $display("FAIL ignore_result: got %0h want %0h", bus.result, ref_prod(a, b)); end
        total++; if (lat != ref_lat(b)) begin bad++; $display("FAIL ignore_latency: got %0d want %0d", lat, ref_lat(b)); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++; $display("FAIL ignore_not_queued: got busy %0b done %0b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] a1, b1, a2, b2, r1, r2; int cyc, nd, t1, t2;
        a1 = 32'h0001_0003; b1 = 32'h8000_0007; a2 = 32'h0BAD_BEEF; b2 = 32'h0000_0F0F;
        r1 = '0; r2 = '0; nd = 0; t1 = 0; t2 = 0;
        bus.op_a = a1; bus.op_b = b1; bus.start = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        while (nd < 2 && cyc < 300) begin
            if (bus.done === 1'b1) begin
                nd++;
                if (nd == 1) begin r1 = bus.result; t1 = cyc; bus.op_a = a2; bus.op_b = b2; end
                else begin r2 = bus.result; t2 = cyc; bus.start = 1'b0; end
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        total++; if (nd != 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", nd); end
        total++; if (r1 !== ref_prod(a1, b1)) begin bad++; $display("FAIL b2b_first: got %0h want %0h", r1, ref_prod(a1, b1)); end
        total++; if (r2 !== ref_prod(a2, b2)) begin bad++; $display("FAIL b2b_second: got %0h want %0h", r2, ref_prod(a2, b2)); end
        total++; if (t1 != ref_lat(b1) || t2 - t1 != ref_lat(b2) + 1) begin
            bad++; $display("FAIL b2b_timing: got %0d/%0d want %0d/%0d", t1, t2 - t1, ref_lat(b1), ref_lat(b2) + 1);
        end
        // Drain the possibly accepted third multiply so later tests start from IDLE
        repeat (40) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run();
        logic [DW-1:0] res; int lat, bc, nd; bit ob, to, xd;
        bus.op_a = 32'h0000_DEAD; bus.op_b = 32'h8000_BEEF; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.alu_op !== '0) begin
            bad++; $display("FAIL midreset_idle: got busy %0b done %0b op %0h want 0 0 0", bus.busy, bus.done, bus.alu_op);
        end
        total++; if (bus.result !== '0) begin bad++; $display("FAIL midreset_result: got %0h want 0", bus.result); end
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) nd++;
            @(posedge clk); #1;
        end
        total++; if (nd != 0) begin bad++; $display("FAIL midreset_no_done: got %0d active cycles want 0", nd); end
        do_mul(32'd3, 32'd4, res, lat, bc, ob, to, xd);
        total++; if (res !== 32'd12 || to) begin bad++; $display("FAIL midreset_fresh: got %0d want 12", res); end
    endtask

    task automatic test_random();
        logic [DW-1:0] a, b, res; int lat, bc, nres, ntim, nop; bit ob, to, xd;
        nres = 0; ntim = 0; nop = 0;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ((i % 50) == 0) a = '0;
            if ((i % 77) == 0) b = '0;
            do_mul(a, b, res, lat, bc, ob, to, xd);
            total++; if (res !== ref_prod(a, b) || to) begin
                bad++; nres++;
                if (nres < 5) $display("FAIL random_result: a %0h b %0h got %0h want %0h", a, b, res, ref_prod(a, b));
            end
            total++; if (lat != ref_lat(b) || bc != ref_lat(b) - 1 || xd) begin
                bad++; ntim++;
                if (ntim < 5) $display("FAIL random_timing: b %0h got lat %0d busy %0d want lat %0d", b, lat, bc, ref_lat(b));
            end
            total++; if (ob) begin
                bad++; nop++;
                if (nop < 5) $display("FAIL random_alu_op: b %0h got non 0/ADD op want 0/ADD", b);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        reset     = 1'b1;
        test_reset();
        test_basic();
        test_corners();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
